// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// Both sides use strict valid/ready semantics: a transfer happens on a rising edge where
// valid && ready are both high; valid must not depend on ready, and payload is only meaningful while valid.
`ifndef GSHARE_GHSR_WIDTH
`define GSHARE_GHSR_WIDTH 8
`endif

interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int GHSR_W = `GSHARE_GHSR_WIDTH
);
  logic                       flush;
  logic                       enq_valid;
  logic                       enq_ready;
  logic [31:0]                enq_pc;
  logic [31:0]                enq_instr;
  logic                       enq_pred_taken;
  logic                       enq_btb_hit;
  logic [31:0]                enq_btb_target;
  logic [GHSR_W-1:0]          enq_ghsr;
  logic                       deq_valid;
  logic                       deq_ready;
  logic [31:0]                deq_pc;
  logic [31:0]                deq_instr;
  logic                       deq_pred_taken;
  logic                       deq_btb_hit;
  logic [31:0]                deq_btb_target;
  logic [GHSR_W-1:0]          deq_ghsr;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output flush, enq_valid, enq_pc, enq_instr, enq_pred_taken, enq_btb_hit,
           enq_btb_target, enq_ghsr, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr, deq_pred_taken, deq_btb_hit,
           deq_btb_target, deq_ghsr, count
  );

  modport slave (
    input  flush, enq_valid, enq_pc, enq_instr, enq_pred_taken, enq_btb_hit,
           enq_btb_target, enq_ghsr, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr, deq_pred_taken, deq_btb_hit,
           deq_btb_target, deq_ghsr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch queue between IF and ID; holds instruction, PC and branch-prediction
// context. Readiness comes from registered occupancy only, so there is no deq->enq path.
`ifndef GSHARE_GHSR_WIDTH
`define GSHARE_GHSR_WIDTH 8
`endif

module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int GHSR_W = `GSHARE_GHSR_WIDTH
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_queue_if.slave  q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              pred_taken;
    logic              btb_hit;
    logic [31:0]       btb_target;
    logic [GHSR_W-1:0] ghsr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_r;
  logic            do_enq;
  logic            do_deq;

  assign q.enq_ready = (count_r < CW'(DEPTH));
  assign q.deq_valid = (count_r != '0);
  assign q.count     = count_r;

  assign do_enq = q.enq_valid && q.enq_ready && !q.flush;
  assign do_deq = q.deq_valid && q.deq_ready && !q.flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is deliberately not reset: only the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= '{pc:         q.enq_pc,
                       instr:      q.enq_instr,
                       pred_taken: q.enq_pred_taken,
                       btb_hit:    q.enq_btb_hit,
                       btb_target: q.enq_btb_target,
                       ghsr:       q.enq_ghsr};
    end
  end

  assign head = q.deq_valid ? mem[rd_ptr] : '0;

  assign q.deq_pc         = head.pc;
  assign q.deq_instr      = head.instr;
  assign q.deq_pred_taken = head.pred_taken;
  assign q.deq_btb_hit    = head.btb_hit;
  assign q.deq_btb_target = head.btb_target;
  assign q.deq_ghsr       = head.ghsr;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked against a
// reference queue of expected head payloads.
`ifndef GSHARE_GHSR_WIDTH
`define GSHARE_GHSR_WIDTH 8
`endif

module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int GHSR_W = `GSHARE_GHSR_WIDTH;
  localparam int EW     = 32 + 32 + 1 + 1 + 32 + GHSR_W;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [EW-1:0] exp_q[$];

  fetch_queue_if #(.DEPTH(DEPTH), .GHSR_W(GHSR_W)) q ();

  fetch_queue #(.DEPTH(DEPTH), .GHSR_W(GHSR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (q)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [31:0] pc);
    logic [31:0]       instr;
    logic [31:0]       tgt;
    logic [GHSR_W-1:0] gh;
    logic              pt;
    logic              bh;
    instr = $urandom;
    tgt   = $urandom;
    gh    = GHSR_W'($urandom);
    pt    = 1'($urandom_range(0, 1));
    bh    = 1'($urandom_range(0, 1));
    return {pc, instr, pt, bh, tgt, gh};
  endfunction

  function automatic logic [EW-1:0] deq_payload();
    return {q.deq_pc, q.deq_instr, q.deq_pred_taken, q.deq_btb_hit, q.deq_btb_target, q.deq_ghsr};
  endfunction

  task automatic check_outputs(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, "_count"}, 128'(q.count), 128'(sz));
    check({tag, "_enq_ready"}, 128'(q.enq_ready), 128'(sz < DEPTH));
    check({tag, "_deq_valid"}, 128'(q.deq_valid), 128'(sz != 0));
    if (sz != 0) check({tag, "_payload"}, 128'(deq_payload()), 128'(exp_q[0]));
    else         check({tag, "_payload_zero"}, 128'(deq_payload()), 128'(0));
  endtask

  // driver: applies inputs at negedge, updates the reference queue at posedge, checks at next negedge
  task automatic cycle(input string tag, input logic ev, input logic [EW-1:0] e,
                       input logic dr, input logic fl);
    logic enq_fire;
    logic deq_fire;
    q.enq_valid = ev;
    {q.enq_pc, q.enq_instr, q.enq_pred_taken, q.enq_btb_hit, q.enq_btb_target, q.enq_ghsr} = e;
    q.deq_ready = dr;
    q.flush     = fl;
    enq_fire = ev && !fl && (exp_q.size() < DEPTH);
    deq_fire = dr && !fl && (exp_q.size() != 0);
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (deq_fire) void'(exp_q.pop_front());
      if (enq_fire) exp_q.push_back(e);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic enq(input string tag, input logic [31:0] pc);
    cycle(tag, 1'b1, mk(pc), 1'b0, 1'b0);
  endtask

  task automatic deq(input string tag);
    cycle(tag, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset_n     = 1'b0;
    q.enq_valid = 1'b1;
    {q.enq_pc, q.enq_instr, q.enq_pred_taken, q.enq_btb_hit, q.enq_btb_target, q.enq_ghsr} = mk(32'hDEAD_0000);
    q.deq_ready = 1'b1;
    q.flush     = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    reset_n     = 1'b1;
    q.enq_valid = 1'b0;
    q.deq_ready = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    q.flush     = 1'b0;
    q.enq_valid = 1'b0;
    q.deq_ready = 1'b0;
    {q.enq_pc, q.enq_instr, q.enq_pred_taken, q.enq_btb_hit, q.enq_btb_target, q.enq_ghsr} = '0;
    @(negedge clk);
    do_reset("reset");

    // fill to full
    for (int k = 0; k < 4; k++) enq("fill", 32'(4 * k));
    check("r034_count", 128'(q.count), 128'(4));
    check("r034_enq_ready", 128'(q.enq_ready), 128'(0));
    check("r034_deq_pc", 128'(q.deq_pc), 128'(32'h0));
    check("r034_deq_valid", 128'(q.deq_valid), 128'(1));

    // full: enqueue rejected while dequeuing
    cycle("full_enq_deq", 1'b1, mk(32'h10), 1'b1, 1'b0);
    check("r035_count", 128'(q.count), 128'(3));
    check("r035_deq_pc", 128'(q.deq_pc), 128'(32'h4));
    check("r035_enq_ready", 128'(q.enq_ready), 128'(1));
    deq("drain");
    check("r035_next_pc", 128'(q.deq_pc), 128'(32'h8));
    deq("drain");
    deq("drain");
    check("r035_empty", 128'(q.deq_valid), 128'(0));
    deq("empty_deq");

    // simultaneous enq/deq at count=2
    enq("fill2", 32'h20);
    enq("fill2", 32'h24);
    cycle("simul", 1'b1, mk(32'h28), 1'b1, 1'b0);
    check("r036_count", 128'(q.count), 128'(2));
    check("r036_deq_pc", 128'(q.deq_pc), 128'(32'h24));
    deq("simul_drain");
    check("r036_next_pc", 128'(q.deq_pc), 128'(32'h28));
    deq("simul_drain");

    // flush beats a same-cycle enqueue
    for (int k = 0; k < 3; k++) enq("pre_flush", 32'h30 + 32'(4 * k));
    cycle("flush", 1'b1, mk(32'h40), 1'b1, 1'b1);
    check("r037_count", 128'(q.count), 128'(0));
    check("r037_deq_valid", 128'(q.deq_valid), 128'(0));
    check("r037_deq_pc", 128'(q.deq_pc), 128'(0));
    deq("post_flush");
    enq("post_flush_enq", 32'h44);
    check("post_flush_pc", 128'(q.deq_pc), 128'(32'h44));
    deq("post_flush_drain");

    // back-to-back pass-through across pointer wrap
    enq("b2b", 32'h100);
    for (int k = 1; k < 10; k++) begin
      cycle("b2b", 1'b1, mk(32'h100 + 32'(4 * k)), 1'b1, 1'b0);
      check("r038_count_le1", 128'(q.count <= 1), 128'(1));
      check("r038_deq_pc", 128'(q.deq_pc), 128'(32'h100 + 32'(4 * k)));
    end
    deq("b2b_drain");

    // reset mid-operation
    for (int k = 0; k < 3; k++) enq("pre_reset", 32'h180 + 32'(4 * k));
    do_reset("mid_reset");
    check("r039_count", 128'(q.count), 128'(0));
    check("r039_enq_ready", 128'(q.enq_ready), 128'(1));
    enq("post_reset", 32'h200);
    check("r039_deq_pc", 128'(q.deq_pc), 128'(32'h200));
    deq("post_reset_drain");

    // random traffic
    for (int n = 0; n < 300; n++) begin
      cycle("rand", 1'($urandom_range(0, 1)), mk($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of queue entries; power of two, >= 2.
REQ-002 SHALL have parameter GHSR_W, default GSHARE_GHSR_WIDTH, giving the width of the gshare history snapshot.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  in  1  discard all entries (redirect from EX).
REQ-006 SHALL have port enq_valid  in  1  fetch offers an entry.
REQ-007 SHALL have port enq_ready  out  1  queue accepts an entry.
REQ-008 SHALL have port enq_pc  in  32  PC of the fetched instruction.
REQ-009 SHALL have port enq_instr  in  32  instruction word.
REQ-010 SHALL have port enq_pred_taken  in  1  predicted taken (already gated by BTB hit).
REQ-011 SHALL have port enq_btb_hit  in  1  BTB hit.
REQ-012 SHALL have port enq_btb_target  in  32  BTB target address.
REQ-013 SHALL have port enq_ghsr  in  GHSR_W  GHSR snapshot.
REQ-014 SHALL have port deq_valid  out  1  head entry available to decode.
REQ-015 SHALL have port deq_ready  in  1  decode consumes the head entry.
REQ-016 SHALL have ports deq_pc, deq_instr, deq_pred_taken, deq_btb_hit, deq_btb_target, deq_ghsr  out  same widths as enq_*  head entry payload.
REQ-017 SHALL have port count  out  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-018 SHALL be an in-order FIFO; entries leave in exactly the order they were accepted.
REQ-019 Enqueue SHALL occur on an edge where enq_valid && enq_ready && !flush.
REQ-020 Dequeue SHALL occur on an edge where deq_valid && deq_ready && !flush.
REQ-021 SHALL drive enq_ready = (count < DEPTH), registered-state only, with no combinational dependence on deq_ready.
REQ-022 SHALL drive deq_valid = (count != 0).
REQ-023 SHALL read the deq_* payload from the head storage entry, with no enq->deq combinational bypass; an entry accepted at edge N is visible on deq_* after edge N (minimum 1-cycle latency).
REQ-024 SHALL force all deq_* payload outputs to zero whenever deq_valid=0.
REQ-025 On a simultaneous enqueue and dequeue, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 When full, SHALL reject enqueue even if deq_ready=1 in the same cycle (count decrements by 1).
REQ-027 When empty, deq_ready SHALL have no effect.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-029 flush SHALL, at the next edge, set count=0 and both pointers to 0; the same-cycle enqueue is dropped and the same-cycle dequeue is not counted.
REQ-030 flush SHALL take priority over enqueue and dequeue; reset_n SHALL take priority over flush.
REQ-031 Storage contents SHALL be written only on enqueue; flush and reset SHALL NOT clear storage.

Reset
REQ-032 While reset_n=0 at an edge: count=0, pointers=0, deq_valid=0, enq_ready=1, deq_* payload=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries identically to power-up reset; the first enqueue after release behaves as if the queue were empty.

Verification
REQ-034 After reset, deq_ready=0, enqueue pc 0x0,0x4,0x8,0xC -> count=4, enq_ready=0, deq_pc=0x0, deq_valid=1.
REQ-035 Queue full, enq_valid=1 (pc 0x10), deq_ready=1 -> next cycle count=3, deq_pc=0x4, pc 0x10 not stored, enq_ready=1.
REQ-036 count=2 (heads 0x20,0x24), enq pc 0x28 with deq_ready=1 -> count=2, deq_pc=0x24, followed by 0x28.
REQ-037 count=3, flush=1 with enq_valid=1 (pc 0x40) -> next cycle count=0, deq_valid=0, deq_pc=0; pc 0x40 never appears.
REQ-038 Ten back-to-back enq/deq pairs with pc 0x100+4k, pred fields varied -> outputs match inputs in order across pointer wrap, count never above 1.
REQ-039 count=3, reset_n=0 for one edge -> count=0, deq_valid=0, enq_ready=1; a subsequent enqueue of pc 0x200 appears on deq_pc one cycle later.
